serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit half adder.
- Adds or subtracts two WIDTH-bit operands BITS_PER_CYCLE bits per clock, using a registered carry chain.
- Uses a start/ready/done handshake and produces sum, carry-out and signed overflow.
- Serves as an area-cheap arithmetic unit for FPGA starter designs, and as the test vehicle for the adder-family benches.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly. STEPS = WIDTH/BITS_PER_CYCLE.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
sub  input  1  0 = a+b+c_in, 1 = a-b (c_in ignored); sampled on accept.
a  input  WIDTH  operand A; sampled on accept.
b  input  WIDTH  operand B; sampled on accept.
c_in  input  1  carry-in for add; sampled on accept.
ready  output  1  block can accept start this cycle.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when results update.
sum  output  WIDTH  result; held stable until the next done.
c_out  output  1  carry out of the MSB. For sub, c_out=1 means no borrow.
ovf  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- States are IDLE and RUN. A step counter counts 0..STEPS-1.
- Reset at a clock edge with rst=1 forces:
  - state=IDLE, counter=0
  - ready=1, busy=0, done=0
  - sum=0, c_out=0, ovf=0
- Reset mid-RUN aborts the operation: no done pulse is issued, and the partial result is discarded.
- Accept condition: start=1 and ready=1 at an edge. At that edge:
  - Latch A=a.
  - Latch B=b if sub=0, or B=~b if sub=1.
  - Set carry register = sub ? 1 : c_in.
  - Set counter=0 and enter RUN.
- start while ready=0 is ignored. It is not queued.
- In RUN, at each edge:
  - Add chunk k (bits k*BPC .. k*BPC+BPC-1) of A and B plus the carry register.
  - Write the chunk sum into the working result.
  - Update the carry register.
- On the final chunk (counter=STEPS-1):
  - Capture the carry into the MSB for ovf.
  - Load sum, c_out and ovf from the working result, the final carry and ovf.
  - Assert done=1 for exactly the following cycle.
  - Return to IDLE.
- Latency: a start accepted at edge t produces done=1 in the cycle after edge t+STEPS. Results are valid in that same cycle.
- ready=1 in IDLE, including the done cycle. Back-to-back operations are allowed: a start accepted during the done cycle begins immediately.
- busy = (state==RUN). ready = ~busy.
- sum, c_out and ovf change only on the done edge or on reset. Inputs a, b, sub and c_in may change freely after accept.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Simultaneous rst and start: rst wins and no operation starts.

Test Plan:
1. Add with signed overflow. WIDTH=8, BPC=1; a=0x5A, b=0x3C, sub=0, c_in=0, start for 1 cycle. Required response:
   - ready=0 and busy=1 for 8 cycles.
   - done pulses once, 8 edges after accept.
   - sum=0x96, c_out=0, ovf=1.
2. Subtract with borrow. WIDTH=8; a=0x10, b=0x20, sub=1. Required: sum=0xF0, c_out=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1. Required: sum=0x7F, c_out=1, ovf=1.
3. Carry-out and carry-in handling. WIDTH=8; a=0xFF, b=0x01, c_in=0. Required: sum=0x00, c_out=1, ovf=0. Then a=0xFF, b=0x00, c_in=1. Required: sum=0x00, c_out=1.
4. Handshake. Assert start again 3 cycles after accept with different operands. Required: the second start is ignored, the first result is unchanged, and there is exactly one done. Then assert start during the done cycle. Required: the new operation is accepted and a second done arrives 8 edges later.
5. Reset mid-operation. Assert rst for 1 cycle at step 4. Required:
   - ready=1, busy=0, sum=0, c_out=0, ovf=0 on the next cycle.
   - No done pulse.
   - A following operation completes correctly.
6. Exhaustive check. WIDTH=4, BPC=2: apply all 2*2*16*16 combinations of sub/c_in/a/b. Required:
   - done arrives 2 edges after each accept.
   - sum, c_out and ovf match a behavioural model in every case.
   - Print each mismatch and halt at end of run.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract unit that consumes BITS_PER_CYCLE
// bits of each operand per clock through a registered carry, with a
// start/ready/done handshake and sum, carry-out and signed-overflow results.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic                      accept;
  logic                      last_step;
  int                        chunk_lsb;
  logic [BITS_PER_CYCLE-1:0] chunk_a;
  logic [BITS_PER_CYCLE-1:0] chunk_b;
  logic [BITS_PER_CYCLE-1:0] chunk_s;
  logic                      chunk_cmsb;  // carry into the top bit of the chunk
  logic                      chunk_cout;  // carry out of the top bit of the chunk

  // A request is only taken while idle; in RUN it is silently dropped.
  assign accept    = start && (state_q == IDLE);
  assign last_step = (state_q == RUN) && (cnt_q == LAST_STEP);
  assign chunk_lsb = int'(cnt_q) * BITS_PER_CYCLE;
  assign chunk_a   = a_q[chunk_lsb +: BITS_PER_CYCLE];
  assign chunk_b   = b_q[chunk_lsb +: BITS_PER_CYCLE];

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> IDLE after the last chunk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy  = (state_q == RUN);
    ready = (state_q != RUN);
  end

  // Ripple add of one chunk plus the registered carry; the carry into the
  // chunk's top bit is kept so the final chunk can produce signed overflow.
  always_comb begin
    logic [BITS_PER_CYCLE:0] c;
    c       = '0;
    chunk_s = '0;
    c[0]    = carry_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_s[i] = chunk_a[i] ^ chunk_b[i] ^ c[i];
      c[i+1]     = (chunk_a[i] & chunk_b[i]) | (chunk_a[i] & c[i]) |
                   (chunk_b[i] & c[i]);
    end
    chunk_cmsb = c[BITS_PER_CYCLE-1];
    chunk_cout = c[BITS_PER_CYCLE];
  end

  // Datapath next-state: latch operands on accept, accumulate chunks in RUN,
  // publish the result on the last chunk.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept) begin
      // Subtraction is a + ~b + 1, so invert B and preload the carry.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : c_in;
      cnt_d   = '0;
      work_d  = '0;
    end else if (state_q == RUN) begin
      work_d[chunk_lsb +: BITS_PER_CYCLE] = chunk_s;
      carry_d = chunk_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_step) begin
        sum_d   = work_d;
        c_out_d = chunk_cout;
        ovf_d   = chunk_cmsb ^ chunk_cout;
        done_d  = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  // Datapath registers; reset clears the published result and drops any pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-per-cycle instance for directed and
// random operations, and a 4-bit/2-bits-per-cycle instance swept exhaustively.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8, cin8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, sub4, cin4, ready4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .c_in(cin8), .ready(ready8), .busy(busy8), .done(done8), .sum(sum8),
    .c_out(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .c_in(cin4), .ready(ready4), .busy(busy4), .done(done4), .sum(sum4),
    .c_out(cout4), .ovf(ovf4)
  );

  // Reference: integer arithmetic; overflow when the signed result leaves range.
  function automatic void model(input int w, input int av, input int bv,
                                input bit s, input bit ci,
                                output int es, output bit ec, output bit eo);
    int mask, bb, cie, full, sa, sb, sr;
    mask = (1 << w) - 1;
    bb   = s ? (~bv & mask) : (bv & mask);
    cie  = s ? 1 : int'(ci);
    full = av + bb + cie;
    es   = full & mask;
    ec   = ((full >> w) & 1) != 0;
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bb >= (1 << (w - 1))) ? bb - (1 << w) : bb;
    sr   = sa + sb + cie;
    eo   = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
  endfunction

  // Issue one op on the 8-bit DUT; return edges-to-done (-1 on timeout) and
  // the number of cycles seen with busy=1/ready=0. Leaves time in the done cycle.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit s,
                      input bit ci, output int lat, output int busy_cyc);
    a8 = av; b8 = bv; sub8 = s; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    lat = -1;
    busy_cyc = (busy8 === 1'b1 && ready8 === 1'b0) ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
      if (busy8 === 1'b1 && ready8 === 1'b0) busy_cyc++;
    end
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input bit s,
                      input bit ci, output int lat);
    a4 = av; b4 = bv; sub4 = s; cin4 = ci; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int dones;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready8, busy8, done8, cout8, ovf8} !== 5'b10000 || sum8 !== 8'h00) begin
      errors++;
      $display("FAIL reset8: got rdy=%b busy=%b done=%b sum=%h cout=%b ovf=%b required 1 0 0 00 0 0",
               ready8, busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({ready4, busy4, done4, cout4, ovf4} !== 5'b10000 || sum4 !== 4'h0) begin
      errors++;
      $display("FAIL reset4: got rdy=%b busy=%b done=%b sum=%h required 1 0 0 0",
               ready4, busy4, done4, sum4);
    end
    // Reset together with start: reset must win.
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_and_start: busy=%b required 0", busy8);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_and_start_done: done pulses=%0d required 0", dones);
    end
    $display("test_reset done");
  endtask

  task automatic test_add_ovf;
    int lat, bc;
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bc);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL add_latency: got %0d required 8", lat); end
    checks++;
    if (bc != 8) begin errors++; $display("FAIL add_busy_cycles: got %0d required 8", bc); end
    checks++;
    if (sum8 !== 8'h96 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL add_result: got sum=%h cout=%b ovf=%b required 96 0 1", sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || sum8 !== 8'h96) begin
      errors++;
      $display("FAIL add_pulse_hold: got done=%b sum=%h required 0 96", done8, sum8);
    end
    $display("test_add_ovf: 5A+3C sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
  endtask

  task automatic test_sub;
    int lat, bc;
    run8(8'h10, 8'h20, 1'b1, 1'b0, lat, bc);
    checks++;
    if (lat != 8 || sum8 !== 8'hF0 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: got lat=%0d sum=%h cout=%b ovf=%b required 8 F0 0 0",
               lat, sum8, cout8, ovf8);
    end
    $display("test_sub: 10-20 sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
    run8(8'h80, 8'h01, 1'b1, 1'b1, lat, bc);
    checks++;
    if (lat != 8 || sum8 !== 8'h7F || cout8 !== 1'b1 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: got lat=%0d sum=%h cout=%b ovf=%b required 8 7F 1 1",
               lat, sum8, cout8, ovf8);
    end
    $display("test_sub: 80-01 sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
  endtask

  task automatic test_carry;
    int lat, bc;
    run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
    checks++;
    if (lat != 8 || sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL carry_out: got lat=%0d sum=%h cout=%b ovf=%b required 8 00 1 0",
               lat, sum8, cout8, ovf8);
    end
    $display("test_carry: FF+01 sum=%h cout=%b", sum8, cout8);
    run8(8'hFF, 8'h00, 1'b0, 1'b1, lat, bc);
    checks++;
    if (lat != 8 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL carry_in: got lat=%0d sum=%h cout=%b required 8 00 1", lat, sum8, cout8);
    end
    $display("test_carry: FF+00+1 sum=%h cout=%b", sum8, cout8);
  endtask

  task automatic test_handshake;
    int lat, dones, first_k;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin lat = k; break; end
      if (k == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;  // must be ignored
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    checks++;
    if (lat != 8 || sum8 !== 8'h46) begin
      errors++;
      $display("FAIL busy_start_ignored: got lat=%0d sum=%h required 8 46", lat, sum8);
    end
    // Start during the done cycle must be accepted immediately.
    a8 = 8'h70; b8 = 8'h10; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dones = 0; first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        dones++;
        if (first_k < 0) first_k = k;
      end
    end
    checks++;
    if (dones != 1 || first_k != 8) begin
      errors++;
      $display("FAIL back_to_back: got dones=%0d at edge %0d required 1 at 8", dones, first_k);
    end
    checks++;
    if (sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_result: got sum=%h cout=%b ovf=%b required 80 0 1",
               sum8, cout8, ovf8);
    end
    $display("test_handshake: first=46 lat=%0d second sum=%h", lat, sum8);
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones;
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({ready8, busy8, done8, cout8, ovf8} !== 5'b10000 || sum8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b busy=%b done=%b sum=%h cout=%b ovf=%b required 1 0 0 00 0 0",
               ready8, busy8, done8, sum8, cout8, ovf8);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", dones);
    end
    run8(8'h21, 8'h43, 1'b0, 1'b1, lat, bc);
    checks++;
    if (lat != 8 || sum8 !== 8'h65 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: got lat=%0d sum=%h cout=%b ovf=%b required 8 65 0 0",
               lat, sum8, cout8, ovf8);
    end
    $display("test_reset_mid: recovery sum=%h", sum8);
  endtask

  task automatic test_random;
    int lat, bc, es, errs_before;
    bit ec, eo, s, ci;
    logic [7:0] av, bv;
    errs_before = errors;
    for (int n = 0; n < 200; n++) begin
      av = 8'($urandom); bv = 8'($urandom);
      s = 1'($urandom); ci = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run8(av, bv, s, ci, lat, bc);
      model(8, int'(av), int'(bv), s, ci, es, ec, eo);
      checks++;
      if (lat != 8 || {24'b0, sum8} !== es || cout8 !== ec || ovf8 !== eo) begin
        errors++;
        $display("FAIL random8: a=%h b=%h sub=%b cin=%b got lat=%0d sum=%h cout=%b ovf=%b required 8 %h %b %b",
                 av, bv, s, ci, lat, sum8, cout8, ovf8, es[7:0], ec, eo);
      end
    end
    $display("test_random: 200 ops, %0d errors", errors - errs_before);
  endtask

  task automatic test_exhaustive;
    int lat, es, errs_before;
    bit ec, eo;
    errs_before = errors;
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++) begin
            run4(4'(av), 4'(bv), 1'(s), 1'(ci), lat);
            model(4, av, bv, 1'(s), 1'(ci), es, ec, eo);
            checks++;
            if (lat != 2 || {28'b0, sum4} !== es || cout4 !== ec || ovf4 !== eo) begin
              errors++;
              $display("FAIL exhaustive4: a=%h b=%h sub=%0d cin=%0d got lat=%0d sum=%h cout=%b ovf=%b required 2 %h %b %b",
                       av, bv, s, ci, lat, sum4, cout4, ovf4, es[3:0], ec, eo);
            end
          end
    $display("test_exhaustive: 1024 ops, %0d errors", errors - errs_before);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_add_ovf();
    test_sub();
    test_carry();
    test_handshake();
    test_reset_mid();
    test_random();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
